// File: rtl/ballot_collector_if.sv
// Ballot stream between the ballot source and the collector.
// Valid/ready handshake carrying a voter ID and a round-close flag.
interface ballot_collector_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_id;
  logic       in_last;

  modport master (
    output in_valid,
    output in_id,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_id,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/ballot_collector.sv
// Ballot collector: stages one voting round into voter masks.
// Emits the round as a one-cycle strobe, flags dup/bad ballots.
module ballot_collector #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  ballot_collector_if.slave   bus,
  output logic [31:0]         np,
  output logic [7:0]          vip,
  output logic                vvip,
  output logic                out_valid,
  output logic [7:0]          round_cnt,
  output logic                err_dup,
  output logic                err_id
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state;
  logic [31:0]     s_np;
  logic [7:0]      s_vip;
  logic            s_vvip;
  logic [31:0]     n_np;
  logic [7:0]      n_vip;
  logic            n_vvip;
  logic [TO_W-1:0] idle;
  logic            acc;
  logic            dup;
  logic            bad;
  logic            tmo;
  logic            close;

  assign bus.in_ready = !reset && (state != EMIT);
  assign acc = bus.in_valid && bus.in_ready;

  assign tmo = (TIMEOUT != 0) && (state == COLLECT)
            && !acc && (idle == TO_LAST);
  assign close = (acc && bus.in_last) || tmo;

  // Staging masks as they would look after the current ballot.
  always_comb begin
    n_np   = s_np;
    n_vip  = s_vip;
    n_vvip = s_vvip;
    dup    = 1'b0;
    bad    = 1'b0;
    if (acc) begin
      unique case (1'b1)
        (bus.in_id[5] == 1'b0): begin
          dup = s_np[bus.in_id[4:0]];
          n_np[bus.in_id[4:0]] = 1'b1;
        end
        (bus.in_id[5:3] == 3'b100): begin
          dup = s_vip[bus.in_id[2:0]];
          n_vip[bus.in_id[2:0]] = 1'b1;
        end
        (bus.in_id == 6'd40): begin
          dup    = s_vvip;
          n_vvip = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
  end

  // Round FSM, staging, idle timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_np      <= '0;
      s_vip     <= '0;
      s_vvip    <= 1'b0;
      idle      <= '0;
      np        <= '0;
      vip       <= '0;
      vvip      <= 1'b0;
      out_valid <= 1'b0;
      round_cnt <= '0;
      err_dup   <= 1'b0;
      err_id    <= 1'b0;
    end else begin
      np        <= '0;
      vip       <= '0;
      vvip      <= 1'b0;
      out_valid <= 1'b0;
      if (acc) begin
        s_np   <= n_np;
        s_vip  <= n_vip;
        s_vvip <= n_vvip;
        if (dup) err_dup <= 1'b1;
        if (bad) err_id  <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (acc) begin
            idle  <= '0;
            state <= bus.in_last ? EMIT : COLLECT;
          end
        end
        COLLECT: begin
          if (acc) begin
            idle <= '0;
          end else if (idle != TO_SAT) begin
            idle <= idle + 1'b1;
          end
          if (close) state <= EMIT;
        end
        EMIT: begin
          state     <= IDLE;
          s_np      <= '0;
          s_vip     <= '0;
          s_vvip    <= 1'b0;
          round_cnt <= round_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
      if (close) begin
        np        <= n_np;
        vip       <= n_vip;
        vvip      <= n_vvip;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Bench for ballot_collector: directed plan plus random traffic.
// A round-level reference model predicts every cycle's outputs.
module tb_ballot_collector;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  ballot_collector_if bus();
  ballot_collector_if bus2();

  logic [31:0] np,  np2;
  logic [7:0]  vip, vip2;
  logic        vvip, vvip2;
  logic        out_valid, out_valid2;
  logic [7:0]  round_cnt, round_cnt2;
  logic        err_dup, err_dup2;
  logic        err_id, err_id2;

  ballot_collector #(.TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .np(np), .vip(vip), .vvip(vvip),
    .out_valid(out_valid), .round_cnt(round_cnt),
    .err_dup(err_dup), .err_id(err_id)
  );

  ballot_collector #(.TIMEOUT(0), .TO_W(5)) dut0 (
    .clk(clk), .reset(reset2), .bus(bus2),
    .np(np2), .vip(vip2), .vvip(vvip2),
    .out_valid(out_valid2), .round_cnt(round_cnt2),
    .err_dup(err_dup2), .err_id(err_id2)
  );

  int tests = 0;
  int fails = 0;

  bit [31:0] m_np;
  bit [7:0]  m_vip;
  bit        m_vvip;
  bit        m_emit;
  bit        m_open;
  int        m_idle;
  int        m_rounds;
  bit        m_dup;
  bit        m_eid;
  bit [31:0] e_np;
  bit [7:0]  e_vip;
  bit        e_vvip;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input bit [5:0] id,
                            input bit l, input bit r);
    int   k;
    bit   a;
    e_np   = '0;
    e_vip  = '0;
    e_vvip = 1'b0;
    if (r) begin
      m_np = '0; m_vip = '0; m_vvip = 0;
      m_emit = 0; m_open = 0; m_idle = 0;
      m_rounds = 0; m_dup = 0; m_eid = 0;
    end else if (m_emit) begin
      m_np = '0; m_vip = '0; m_vvip = 0;
      m_emit = 0; m_open = 0;
      m_rounds = (m_rounds + 1) % 256;
    end else begin
      a = v;
      k = int'(id);
      if (a) begin
        if (k < 32) begin
          if (((m_np >> k) & 32'd1) != 0) m_dup = 1;
          else m_np = m_np | (32'd1 << k);
        end else if (k < 40) begin
          if (((m_vip >> (k - 32)) & 8'd1) != 0) m_dup = 1;
          else m_vip = m_vip | (8'd1 << (k - 32));
        end else if (k == 40) begin
          if (m_vvip) m_dup = 1;
          else m_vvip = 1;
        end else begin
          m_eid = 1;
        end
        m_idle = 0;
        if (l) begin
          m_emit = 1; m_open = 0;
        end else begin
          m_open = 1;
        end
      end else if (m_open) begin
        m_idle++;
        if (m_idle >= TO) begin
          m_emit = 1; m_open = 0;
        end
      end
      if (m_emit) begin
        e_np = m_np; e_vip = m_vip; e_vvip = m_vvip;
      end
    end
  endtask

  task automatic step(input bit v, input bit [5:0] id,
                      input bit l, input bit r = 1'b0);
    bus.in_valid = v;
    bus.in_id    = id;
    bus.in_last  = l;
    reset        = r;
    #1;
    chk("in_ready", bus.in_ready, 32'(!r && !m_emit));
    @(posedge clk);
    model_edge(v, id, l, r);
    #1;
    chk("out_valid", out_valid, 32'(m_emit));
    chk("np", np, e_np);
    chk("vip", vip, 32'(e_vip));
    chk("vvip", vvip, 32'(e_vvip));
    chk("round_cnt", round_cnt, 32'(m_rounds));
    chk("err_dup", err_dup, 32'(m_dup));
    chk("err_id", err_id, 32'(m_eid));
  endtask

  task automatic idle_step();
    step(1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [10] = '{3, 7, 11, 15, 19, 23, 27, 31, 35, 39};
    int burst;
    bit v, l, r;
    bit [5:0] id;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_id = '0; bus.in_last = 1'b0;
    reset2 = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_id = '0; bus2.in_last = 1'b0;
    @(posedge clk); #1;
    reset2 = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_id = 6'd12;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      chk("to0_no_emit", out_valid2, 32'd0);
    end
    chk("to0_rounds", round_cnt2, 32'd0);

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    foreach (ids[i]) step(1, 6'(ids[i]), 0);
    chk("t1_pre", out_valid, 32'd0);
    step(1, 6'd40, 1);
    chk("t1_valid", out_valid, 32'd1);
    chk("t1_np", np, 32'h88888888);
    chk("t1_vip", vip, 32'h88);
    chk("t1_vvip", vvip, 32'd1);
    idle_step();
    chk("t1_after", out_valid, 32'd0);
    chk("t1_rounds", round_cnt, 32'd1);

    step(1, 6'd5, 0);
    step(1, 6'd5, 0);
    step(1, 6'd0, 1);
    chk("t2_np", np, 32'h21);
    chk("t2_dup", err_dup, 32'd1);
    idle_step();
    step(1, 6'd9, 1);
    idle_step();
    chk("t2_dup_sticky", err_dup, 32'd1);

    step(1, 6'd50, 1);
    chk("t3_valid", out_valid, 32'd1);
    chk("t3_np", np, 32'd0);
    chk("t3_err_id", err_id, 32'd1);
    idle_step();
    chk("t3_rounds", round_cnt, 32'd4);

    step(1, 6'd12, 0);
    for (int i = 0; i < 15; i++) idle_step();
    chk("t4_early", out_valid, 32'd0);
    idle_step();
    chk("t4_valid", out_valid, 32'd1);
    chk("t4_np", np, 32'h1000);
    idle_step();

    step(1, 6'd1, 1);
    bus.in_valid = 1'b1; bus.in_id = 6'd2; bus.in_last = 1'b0;
    #1;
    chk("t5_ready_emit", bus.in_ready, 32'd0);
    step(1, 6'd2, 0);
    step(1, 6'd2, 1);
    chk("t5_np", np, 32'h4);
    idle_step();

    step(0, 0, 0, 1);
    step(1, 6'd1, 0);
    step(1, 6'd2, 0);
    step(0, 0, 0, 1);
    chk("t6_no_emit", out_valid, 32'd0);
    step(1, 6'd4, 1);
    chk("t6_np", np, 32'h10);
    idle_step();
    chk("t6_rounds", round_cnt, 32'd1);

    step(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin
      step(1, 6'd41, 1);
      idle_step();
    end
    chk("wrap_rounds", round_cnt, 32'd0);

    step(0, 0, 0, 1);
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if (burst == 0 && $urandom_range(0, 39) == 0)
        burst = $urandom_range(10, 20);
      if (burst > 0) begin
        v = 1'b0;
        burst--;
      end else begin
        v = ($urandom_range(0, 3) != 0);
      end
      id = 6'($urandom_range(0, 47));
      l  = ($urandom_range(0, 9) == 0);
      step(v, id, l, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Upstream stage of the weighted voter. Accepts ballots one at a time over a valid/ready stream, each tagged with a voter ID.
- Assembles one voting round into np[31:0] / vip[7:0] / vvip bitmasks and presents them to the voter for exactly one cycle, flagged by out_valid.
- Outside that cycle the masks are all-zero, so the voter never double-counts a round.
- Flags duplicate and out-of-range ballots.

Parameters:
- TIMEOUT, 16, idle cycles in COLLECT with no accepted ballot before the round auto-closes; 0 disables auto-close.
- TO_W, 5, width of idle counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ballot present.
- in_ready  out  1  collector can accept; transfer occurs on an edge where in_valid && in_ready.
- in_id  in  6  voter ID: 0-31 normal (np bit id), 32-39 VIP (vip bit id-32), 40 VVIP, 41-63 invalid.
- in_last  in  1  ballot closes the round.
- np  out  32  normal-voter mask, to voter.
- vip  out  8  VIP mask, to voter.
- vvip  out  1  VVIP vote, to voter.
- out_valid  out  1  one-cycle strobe marking the masks as a complete round.
- round_cnt  out  8  rounds emitted; wraps 255->0.
- err_dup  out  1  sticky: a duplicate ballot was received.
- err_id  out  1  sticky: an out-of-range ballot was received.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset state:
  - state=IDLE; staging masks, np, vip, vvip, out_valid, round_cnt, err_dup, err_id and idle counter all 0.
  - in_ready=0 while reset is high; ballots presented during reset are dropped.
- in_ready = !reset && state!=EMIT (combinational from state).
- FSM (IDLE, COLLECT, EMIT):
  - IDLE: accepted ballot without in_last -> COLLECT; accepted ballot with in_last -> EMIT.
  - COLLECT: accepted ballot with in_last -> EMIT; idle counter reaches TIMEOUT (TIMEOUT!=0) -> EMIT; else stay.
  - EMIT: lasts exactly 1 cycle, then IDLE.
- Ballot handling on accept:
  - Valid ID whose staging bit is clear: set that bit.
  - Valid ID whose staging bit is already set: staging unchanged; err_dup<=1.
  - ID 41-63: staging unchanged; err_id<=1. in_last on such a ballot still closes the round.
- Idle counter:
  - Cleared on every accepted ballot and on entry to COLLECT.
  - Increments each COLLECT cycle with no accept; saturates at TIMEOUT.
- Outputs:
  - np/vip/vvip/out_valid are registered. They equal the staging masks / 1 only during the EMIT cycle, and are 0 in all other cycles.
  - Latency: a last ballot accepted on edge k gives out_valid=1 and valid masks in the cycle after edge k, i.e. exactly one cycle.
  - A timeout close at edge k likewise gives output in the cycle after edge k.
- On leaving EMIT: staging masks cleared, round_cnt+=1 (mod 256).
- An empty round is legal: an invalid-ID last ballot in IDLE emits all-zero masks with out_valid=1, and round_cnt increments.
- Reset mid-COLLECT or during EMIT: staged votes discarded with no emit; outputs are 0 in the cycle after the reset edge.
- err_dup and err_id clear only on reset.

Test Plan:
- Reset, then IDs 3,7,11,15,19,23,27,31,35,39 one per cycle, then 40 with in_last -> exactly one cycle with np=32'h88888888, vip=8'h88, vvip=1, out_valid=1; all zero before and after; round_cnt=1.
- ID 5, then ID 5 again, then ID 0 with in_last -> np=32'h00000021, err_dup=1 and stays 1 through the next round; out_valid pulses once.
- ID 50 with in_last from IDLE -> all-zero masks, out_valid=1 for one cycle, err_id=1, round_cnt increments.
- ID 12, then in_valid=0 for 16 cycles -> auto-close; np=32'h00001000 with out_valid in the cycle after the 16th idle edge. With TIMEOUT=0, no emit after 100 idle cycles.
- in_valid held high across a close -> in_ready=0 during EMIT and that ballot is not taken; it is accepted next cycle into the new round.
- IDs 1,2 accepted, then reset for 1 cycle, then ID 4 with in_last -> np=32'h00000010 only; round_cnt=1; no emit of the discarded votes. Also run 256 rounds -> round_cnt wraps to 0.
